// File: rtl/seven_seg_scanner_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner_if
//
// Bundles the data/control signals of the seven-segment scanner.
//
// Parameter:
//   NUM_DIGITS : number of multiplexed digits (2..8)
//
// Signals:
//   value      : 4*NUM_DIGITS hex nibbles, nibble k belongs to digit k
//   dp_in      : per-digit decimal point request, active-high
//   load       : single-cycle strobe capturing value/dp_in into staging
//   digit      : registered nibble for the external seven_seg_decoder
//   an_n       : registered anode enables, active-low, one-hot-or-none
//   dp_n       : registered decimal point, active-low
//   digit_idx  : index of the current digit slot
//   frame_done : single-cycle pulse when the scan wraps back to digit 0
//   pending    : staged data waiting for the next frame wrap
//
// Modports:
//   master : the client that supplies display data and watches the scan
//   slave  : the scanner itself
// ---------------------------------------------------------------------------
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [3:0]              digit;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    dp_n;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output value,
        output dp_in,
        output load,
        input  digit,
        input  an_n,
        input  dp_n,
        input  digit_idx,
        input  frame_done,
        input  pending
    );

    modport slave (
        input  value,
        input  dp_in,
        input  load,
        output digit,
        output an_n,
        output dp_n,
        output digit_idx,
        output frame_done,
        output pending
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexes NUM_DIGITS hex digits onto a common seven-segment bus.
// Every digit owns a slot of REFRESH_DIV clock cycles; the first
// BLANK_CYCLES cycles of each slot keep all anodes off (ghosting guard),
// the remainder of the slot drives the anode of the current digit.
// New display data is captured into a staging register by 'load' and is
// only copied into the displayed (shadow) register on the frame wrap, so a
// frame never mixes old and new data.
//
// Parameters:
//   NUM_DIGITS   : number of digits, 2..8
//   REFRESH_DIV  : clk cycles per digit slot, 4..2^20
//   BLANK_CYCLES : all-off cycles at the start of each slot, 1..REFRESH_DIV-1
//
// Ports:
//   clk : sole clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : seven_seg_scanner_if.slave
//         inputs  value, dp_in, load
//         outputs digit, an_n, dp_n, digit_idx, frame_done, pending
//         (all outputs are registered)
//
// Build option:
//   SEG_SCAN_LZB_EN : when defined, leading-zero blanking keeps the anode of
//                     digit k > 0 off when nibbles k..NUM_DIGITS-1 are all
//                     zero and digit k has no decimal point. Slot timing and
//                     frame_done are not affected.
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_scanner_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Nibble of 'data' belonging to digit 'idx' (mask-and-or mux, no
    // out-of-range indexing when NUM_DIGITS is not a power of two).
    function automatic logic [3:0] nibble_at(input logic [VAL_W-1:0] data,
                                             input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib = nib | (data[4*k +: 4] & {4{idx == IDX_W'(k)}});
        end
        return nib;
    endfunction

    // Decimal-point request of digit 'idx'.
    function automatic logic dp_at(input logic [NUM_DIGITS-1:0] dp,
                                   input logic [IDX_W-1:0]      idx);
        logic sel;
        sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel = sel | (dp[k] & (idx == IDX_W'(k)));
        end
        return sel;
    endfunction

    // Active-low anode pattern with only digit 'idx' enabled.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] an;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an[k] = ~(idx == IDX_W'(k));
        end
        return an;
    endfunction

`ifdef SEG_SCAN_LZB_EN
    // True when digit 'idx' is a leading zero that should stay dark:
    // not digit 0, no decimal point, and it and every more significant
    // nibble are zero.
    function automatic logic lzb_hide(input logic [VAL_W-1:0]      data,
                                      input logic [NUM_DIGITS-1:0] dp,
                                      input logic [IDX_W-1:0]      idx);
        logic upper_nz;
        logic sel_dp;
        upper_nz = 1'b0;
        sel_dp   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            upper_nz = upper_nz | ((k >= int'(idx)) && (data[4*k +: 4] != 4'h0));
            sel_dp   = sel_dp   | (dp[k] & (idx == IDX_W'(k)));
        end
        return (idx != {IDX_W{1'b0}}) & ~upper_nz & ~sel_dp;
    endfunction
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_next_s;
    state_t                state_r;
    state_t                state_next_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_next_s;

    logic [VAL_W-1:0]      staging_val_r;
    logic [VAL_W-1:0]      staging_val_next_s;
    logic [NUM_DIGITS-1:0] staging_dp_r;
    logic [NUM_DIGITS-1:0] staging_dp_next_s;
    logic                  pending_r;
    logic                  pending_next_s;

    logic [VAL_W-1:0]      shadow_val_r;
    logic [VAL_W-1:0]      shadow_val_next_s;
    logic [NUM_DIGITS-1:0] shadow_dp_r;
    logic [NUM_DIGITS-1:0] shadow_dp_next_s;

    logic [3:0]            digit_r;
    logic [3:0]            digit_next_s;
    logic                  dp_n_r;
    logic                  dp_n_next_s;
    logic [NUM_DIGITS-1:0] an_n_r;
    logic [NUM_DIGITS-1:0] an_n_next_s;
    logic                  frame_done_r;
    logic                  frame_done_next_s;

    logic                  slot_end_s;
    logic                  blank_end_s;
    logic                  frame_wrap_s;
    logic                  hide_s;

    // -----------------------------------------------------------------------
    // Timing: prescaler and digit index
    // -----------------------------------------------------------------------

    // Decode slot/frame boundaries and compute the next prescaler and index.
    always_comb begin
        slot_end_s   = (cnt_r == SLOT_LAST);
        blank_end_s  = (cnt_r == BLANK_LAST);
        frame_wrap_s = slot_end_s && (idx_r == IDX_LAST);
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        if (slot_end_s) begin
            cnt_next_s = {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_next_s = {IDX_W{1'b0}};
            end else begin
                idx_next_s = idx_r + IDX_W'(1);
            end
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
            idx_next_s = idx_r;
        end
    end

    // Prescaler and digit index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
            idx_r <= idx_next_s;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: BLANK at the start of every slot, SHOW for the rest
    // -----------------------------------------------------------------------

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BLANK: begin
                if (blank_end_s) begin
                    state_next_s = ST_SHOW;
                end else begin
                    state_next_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (slot_end_s) begin
                    state_next_s = ST_BLANK;
                end else begin
                    state_next_s = ST_SHOW;
                end
            end
            default: begin
                state_next_s = ST_BLANK;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BLANK;
        end else begin
            state_r <= state_next_s;
        end
    end

    // -----------------------------------------------------------------------
    // Data path: staging -> shadow double buffer
    // -----------------------------------------------------------------------

    // Staging captures every load; shadow only changes on the frame wrap.
    // A load on the wrap cycle itself bypasses staging into shadow so it is
    // visible from slot 0 of the frame that starts next, and leaves nothing
    // pending.
    always_comb begin
        staging_val_next_s = staging_val_r;
        staging_dp_next_s  = staging_dp_r;
        pending_next_s     = pending_r;
        shadow_val_next_s  = shadow_val_r;
        shadow_dp_next_s   = shadow_dp_r;

        if (bus.load) begin
            staging_val_next_s = bus.value;
            staging_dp_next_s  = bus.dp_in;
        end else begin
            staging_val_next_s = staging_val_r;
            staging_dp_next_s  = staging_dp_r;
        end

        if (frame_wrap_s) begin
            pending_next_s = 1'b0;
            if (bus.load) begin
                shadow_val_next_s = bus.value;
                shadow_dp_next_s  = bus.dp_in;
            end else if (pending_r) begin
                shadow_val_next_s = staging_val_r;
                shadow_dp_next_s  = staging_dp_r;
            end else begin
                shadow_val_next_s = shadow_val_r;
                shadow_dp_next_s  = shadow_dp_r;
            end
        end else begin
            shadow_val_next_s = shadow_val_r;
            shadow_dp_next_s  = shadow_dp_r;
            if (bus.load) begin
                pending_next_s = 1'b1;
            end else begin
                pending_next_s = pending_r;
            end
        end
    end

    // Staging, pending and shadow registers; reset discards staged data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging_val_r <= {VAL_W{1'b0}};
            staging_dp_r  <= {NUM_DIGITS{1'b0}};
            pending_r     <= 1'b0;
            shadow_val_r  <= {VAL_W{1'b0}};
            shadow_dp_r   <= {NUM_DIGITS{1'b0}};
        end else begin
            staging_val_r <= staging_val_next_s;
            staging_dp_r  <= staging_dp_next_s;
            pending_r     <= pending_next_s;
            shadow_val_r  <= shadow_val_next_s;
            shadow_dp_r   <= shadow_dp_next_s;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------

`ifdef SEG_SCAN_LZB_EN
    assign hide_s = lzb_hide(shadow_val_next_s, shadow_dp_next_s, idx_next_s);
`else
    assign hide_s = 1'b0;
`endif

    // Output next values are derived from the next state/index so that the
    // registered outputs line up with the FSM without an extra cycle of lag.
    // digit/dp_n only move at a slot boundary, so they are stable per slot.
    always_comb begin
        digit_next_s      = digit_r;
        dp_n_next_s       = dp_n_r;
        an_n_next_s       = {NUM_DIGITS{1'b1}};
        frame_done_next_s = frame_wrap_s;

        if (slot_end_s) begin
            digit_next_s = nibble_at(shadow_val_next_s, idx_next_s);
            dp_n_next_s  = ~dp_at(shadow_dp_next_s, idx_next_s);
        end else begin
            digit_next_s = digit_r;
            dp_n_next_s  = dp_n_r;
        end

        if ((state_next_s == ST_SHOW) && !hide_s) begin
            an_n_next_s = anode_for(idx_next_s);
        end else begin
            an_n_next_s = {NUM_DIGITS{1'b1}};
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_r      <= 4'h0;
            dp_n_r       <= 1'b1;
            an_n_r       <= {NUM_DIGITS{1'b1}};
            frame_done_r <= 1'b0;
        end else begin
            digit_r      <= digit_next_s;
            dp_n_r       <= dp_n_next_s;
            an_n_r       <= an_n_next_s;
            frame_done_r <= frame_done_next_s;
        end
    end

    assign bus.digit      = digit_r;
    assign bus.dp_n       = dp_n_r;
    assign bus.an_n       = an_n_r;
    assign bus.digit_idx  = idx_r;
    assign bus.frame_done = frame_done_r;
    assign bus.pending    = pending_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Scoreboard bench for seven_seg_scanner (4 digits, 8-cycle slots, 2 blank
// cycles). A driver process issues one stimulus per clock and pushes the
// output it expects for that cycle; a monitor pops and compares on the
// falling edge. The reference is written in terms of the cycle count since
// reset release: slot = t/8, phase = t%8, digit = slot%4, and a frame shows
// the most recent data loaded on or before the wrap cycle that opened it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [3:0] an_n;
        logic [3:0] digit;
        logic       dp_n;
        logic [1:0] idx;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int          t;
    logic [15:0] disp_val;
    logic [3:0]  disp_dp;
    logic [15:0] latest_val;
    logic [3:0]  latest_dp;
    bit          dirty;

    task automatic model_reset();
        t          = 0;
        disp_val   = 16'h0;
        disp_dp    = 4'h0;
        latest_val = 16'h0;
        latest_dp  = 4'h0;
        dirty      = 1'b0;
    endtask

    function automatic exp_t expect_now(input bit in_reset);
        exp_t e;
        int   slot;
        int   phase;
        int   idx;
        bit   hide;
        if (in_reset) begin
            e.tag   = -1;
            e.an_n  = 4'hF;
            e.digit = 4'h0;
            e.dp_n  = 1'b1;
            e.idx   = 2'd0;
            e.fd    = 1'b0;
            e.pend  = 1'b0;
        end else begin
            slot  = t / RD;
            phase = t % RD;
            idx   = slot % ND;
            hide  = 1'b0;
`ifdef SEG_SCAN_LZB_EN
            hide = (idx > 0) && (disp_dp[idx] == 1'b0) && ((disp_val >> (4 * idx)) == 16'h0);
`endif
            e.tag   = t;
            e.an_n  = (phase < BC || hide) ? 4'hF : ~(4'(1) << idx);
            e.digit = 4'((disp_val >> (4 * idx)) & 16'h000F);
            e.dp_n  = ~disp_dp[idx];
            e.idx   = 2'(idx);
            e.fd    = (phase == 0) && (idx == 0) && (slot > 0);
            e.pend  = dirty;
        end
        return e;
    endfunction

    // One clock of stimulus: push the expectation for this cycle, drive the
    // inputs sampled at the end of it, then advance the model.
    task automatic step(input bit r, input bit ld, input logic [15:0] v, input logic [3:0] d);
        @(posedge clk);
        #1;
        rst = r;
        if (r) begin
            model_reset();
            exp_q.push_back(expect_now(1'b1));
            bus.load  = 1'b0;
            bus.value = 16'h0;
            bus.dp_in = 4'h0;
        end else begin
            exp_q.push_back(expect_now(1'b0));
            bus.load  = ld;
            bus.value = v;
            bus.dp_in = d;
            if (ld) begin
                latest_val = v;
                latest_dp  = d;
                dirty      = 1'b1;
            end
            if ((t % FRAME == FRAME - 1) && dirty) begin
                disp_val = latest_val;
                disp_dp  = latest_dp;
                dirty    = 1'b0;
            end
            t++;
        end
    endtask

    task automatic idle_until(input int target);
        while (t < target) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
        end
    endtask

    function automatic int next_frame();
        return (t / FRAME + 1) * FRAME;
    endfunction

    // Monitor: one comparison per presented cycle
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({bus.an_n, bus.digit, bus.dp_n, bus.digit_idx, bus.frame_done, bus.pending} !==
                    {e.an_n, e.digit, e.dp_n, e.idx, e.fd, e.pend}) begin
                    bad++;
                    $display("FAIL scan t=%0d got an_n=%h digit=%h dp_n=%b idx=%0d fd=%b pend=%b expected an_n=%h digit=%h dp_n=%b idx=%0d fd=%b pend=%b",
                             e.tag, bus.an_n, bus.digit, bus.dp_n, bus.digit_idx, bus.frame_done, bus.pending,
                             e.an_n, e.digit, e.dp_n, e.idx, e.fd, e.pend);
                end
            end
        end
    end

    // Watchdog
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not complete, got t=%0d expected completion", t);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin : stim
        int fb;
        bus.load  = 1'b0;
        bus.value = 16'h0;
        bus.dp_in = 4'h0;
        model_reset();

        // Power-on reset, then 1234 loaded while idle in frame 0
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
        idle_until(6);
        step(1'b0, 1'b1, 16'h1234, 4'h0);
        idle_until(4 * FRAME);

        // Two loads inside one frame: second one wins at the wrap
        fb = next_frame();
        idle_until(fb + 10);
        step(1'b0, 1'b1, 16'hAAAA, 4'h0);
        idle_until(fb + 20);
        step(1'b0, 1'b1, 16'h5555, 4'h0);
        idle_until(fb + 3 * FRAME);

        // Load exactly on the wrap cycle
        fb = next_frame();
        idle_until(fb + FRAME - 1);
        step(1'b0, 1'b1, 16'hBEEF, 4'b0101);
        idle_until(fb + 3 * FRAME);

        // Leading-zero patterns
        step(1'b0, 1'b1, 16'h0042, 4'h0);
        idle_until(next_frame() + 2 * FRAME);
        step(1'b0, 1'b1, 16'h0000, 4'b0100);
        idle_until(next_frame() + 2 * FRAME);

        // Random loads
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                step(1'b0, 1'b1, 16'($urandom), 4'($urandom));
            end else begin
                step(1'b0, 1'b0, 16'h0, 4'h0);
            end
        end

        // Reset during a SHOW phase while a load is pending
        fb = next_frame();
        idle_until(fb + 3);
        step(1'b0, 1'b1, 16'h9876, 4'hF);
        idle_until(fb + RD + 4);
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
        idle_until(3 * FRAME);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
